// File: rtl/vga_tile_sched.sv
// Tile-map line scheduler: fetches one row of tile codes into a line buffer
// at the end of each visible line, and arbitrates game-logic writes into the
// shared single-port tile RAM when no fetch is running.
module vga_tile_sched #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int MAP_COLS = 20,
    parameter int MAP_ROWS = 15
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       vga_blank_z,
    input  logic       wr_req,
    input  logic [8:0] wr_addr,
    input  logic [2:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    output logic [8:0] ram_addr,
    output logic       ram_we,
    output logic [2:0] ram_wdata,
    input  logic [2:0] ram_rdata,
    output logic [2:0] tile_code,
    output logic       fetch_busy
);

    localparam int CW    = $clog2(MAP_COLS + 1);
    localparam int CELLS = MAP_COLS * MAP_ROWS;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q;
    logic [8:0]      addr_q;
    logic            ack_q;
    logic            run_q;
    logic [2:0]      linebuf [MAP_COLS];
    logic [2:0]      tile_p0;

    logic [9:0]      next_y;
    logic            trig_valid;
    logic [8:0]      fetch_base;
    logic            grant;
    logic            reject;

    // Line-end trigger: next displayed line and the tile row it needs
    always_comb begin
        next_y     = (y_pos == 10'(V_TOTAL - 1)) ? 10'd0 : y_pos + 10'd1;
        trig_valid = (x_pos == 10'(H_ACTIVE)) && (next_y < 10'(V_ACTIVE));
        fetch_base = 9'(32'(next_y[8:5]) * MAP_COLS);
    end

    // Next-state logic and write arbitration; the fetch always has priority
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_valid) begin
                    state_d = FETCH;
                end else if (wr_req && !ack_q && run_q) begin
                    // ack_q blocks the cycle after an ack so a held request is not counted twice
                    if (32'(wr_addr) < CELLS) grant  = 1'b1;
                    else                      reject = 1'b1;
                end
            end
            FETCH: begin
                if (col_q == CW'(MAP_COLS - 1)) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A granted write drives the RAM port directly in the grant cycle
    assign ram_we     = grant;
    assign ram_addr   = grant ? wr_addr : addr_q;
    assign ram_wdata  = grant ? wr_data : 3'd0;
    assign wr_ack     = grant | reject;
    assign wr_err     = reject;
    assign fetch_busy = (state_q != IDLE);
    assign tile_code  = tile_p0;

    // State register, fetch column counter and read address generator
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= wr_ack;
            run_q   <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (trig_valid) begin
                        col_q  <= '0;
                        addr_q <= fetch_base;
                    end else if (grant) begin
                        addr_q <= wr_addr;
                    end
                end
                FETCH: begin
                    col_q <= col_q + CW'(1);
                    if (col_q != CW'(MAP_COLS - 1)) addr_q <= addr_q + 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Line buffer capture: RAM data lags the issued address by one cycle
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAP_COLS; i++) linebuf[i] <= '0;
        end else if ((state_q == FETCH && col_q != '0) || state_q == DRAIN) begin
            linebuf[col_q - CW'(1)] <= ram_rdata;
        end
    end

    // Pixel stage p0: tile lookup for the current pixel, forced to 0 in blanking
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tile_p0 <= '0;
        end else if (vga_blank_z && (32'(x_pos[9:5]) < MAP_COLS)) begin
            tile_p0 <= linebuf[x_pos[9:5]];
        end else begin
            tile_p0 <= '0;
        end
    end

endmodule

// File: tb/tb_vga_tile_sched.sv
// Scoreboard bench for vga_tile_sched: stimulus pushes expected RAM-port
// events, a negedge monitor pops and compares whenever the DUT is active.
module tb_vga_tile_sched;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic       vga_blank_z = 1'b0;
    logic       wr_req = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [2:0] wr_data = '0;
    logic       wr_ack;
    logic       wr_err;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata = '0;
    logic [2:0] tile_code;
    logic       fetch_busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       busy;
        logic       chk_addr;
        logic [8:0] addr;
        logic       we;
        logic [2:0] wdata;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [2:0] mem [512];

    vga_tile_sched dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .vga_blank_z(vga_blank_z),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .tile_code  (tile_code),
        .fetch_busy (fetch_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Tile RAM model: synchronous write, 1-cycle read latency
    always @(posedge sys_clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic exp_t mk(input logic busy, input logic chk, input int addr,
                                input logic we, input int wdata, input logic ack, input logic err);
        exp_t e;
        e.busy = busy; e.chk_addr = chk; e.addr = 9'(addr);
        e.we = we; e.wdata = 3'(wdata); e.ack = ack; e.err = err;
        return e;
    endfunction

    // 20 address cycles then one drain cycle whose address is not checked
    task automatic push_fetch(input int base, input int ncols);
        for (int k = 0; k < ncols; k++) exp_q.push_back(mk(1, 1, base + k, 0, 0, 0, 0));
        if (ncols == 20) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic push_wr(input int addr, input int data);
        exp_q.push_back(mk(0, 1, addr, 1, data, 1, 0));
    endtask

    task automatic push_err();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    endtask

    // Monitor: compare every active RAM-port/handshake cycle against the queue
    always @(negedge sys_clk) begin
        if (fetch_busy || wr_ack || ram_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: busy=%b addr=%0d we=%b wdata=%0d ack=%b err=%b, expected no activity",
                         fetch_busy, ram_addr, ram_we, ram_wdata, wr_ack, wr_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (fetch_busy !== mon_e.busy || (mon_e.chk_addr && ram_addr !== mon_e.addr) ||
                    ram_we !== mon_e.we || ram_wdata !== mon_e.wdata ||
                    wr_ack !== mon_e.ack || wr_err !== mon_e.err) begin
                    fails++;
                    $display("FAIL scoreboard: got busy=%b addr=%0d we=%b wdata=%0d ack=%b err=%b, expected busy=%b addr=%0d(chk=%b) we=%b wdata=%0d ack=%b err=%b",
                             fetch_busy, ram_addr, ram_we, ram_wdata, wr_ack, wr_err,
                             mon_e.busy, mon_e.addr, mon_e.chk_addr, mon_e.we, mon_e.wdata, mon_e.ack, mon_e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic trigger(input int y);
        x_pos = 10'd640;
        y_pos = 10'(y);
        tick();
        x_pos = 10'd700;
    endtask

    // Requester holds its request until it sees wr_ack, then drops it
    task automatic wait_ack(input string name);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge sys_clk);
            if (wr_ack) break;
        end
        if (n == 100) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no wr_ack in 100 cycles, expected wr_ack", name);
        end
        tick();
        wr_req = 1'b0;
    endtask

    task automatic check_tile(input string name, input int col, input int exp);
        x_pos = 10'(col * 32);
        vga_blank_z = 1'b1;
        tick();
        check(name, 32'(tile_code), 32'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(fetch_busy), 0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check({tag, "_ram_we"}, 32'(ram_we), 0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
        check({tag, "_wr_ack"}, 32'(wr_ack), 0);
        check({tag, "_wr_err"}, 32'(wr_err), 0);
        check({tag, "_tile"}, 32'(tile_code), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 3'd0;
        for (int i = 0; i < 20; i++) mem[i] = 3'((i + 3) % 8);
        for (int i = 20; i < 40; i++) mem[i] = 3'((i - 20) % 8);
        x_pos = 10'd700;

        // Reset state, with a write request already pending
        wr_req = 1'b1; wr_addr = 9'd45; wr_data = 3'd6;
        #2;
        check_all_zero("reset");
        repeat (3) tick();
        check("reset_hold_ack", 32'(wr_ack), 0);
        push_wr(45, 6);
        reset_n = 1'b1;
        wait_ack("pending_at_reset");

        // Fetch of row 1 at the end of line 31
        push_fetch(20, 20);
        trigger(31);
        repeat (25) tick();
        check("fetch_done_busy", 32'(fetch_busy), 0);
        y_pos = 10'd32;
        check_tile("tile_col2", 2, 2);
        check_tile("tile_col0", 0, 0);
        check_tile("tile_col7", 7, 7);
        check_tile("tile_col8", 8, 0);
        check_tile("tile_col19", 19, 3);
        vga_blank_z = 1'b0;
        x_pos = 10'd700;

        // Collision: write raised on the trigger cycle waits for the fetch
        wr_req = 1'b1; wr_addr = 9'd25; wr_data = 3'd5;
        push_fetch(20, 20);
        push_wr(25, 5);
        trigger(31);
        wait_ack("collision");
        repeat (3) tick();
        wr_req = 1'b1; wr_addr = 9'd26; wr_data = 3'd1;
        push_wr(26, 1);
        wait_ack("plain_write");
        push_fetch(20, 20);
        trigger(31);
        repeat (25) tick();
        y_pos = 10'd32;
        check_tile("tile_after_collision", 5, 5);
        check_tile("tile_after_write", 6, 1);

        // Blanking forces tile 0
        x_pos = 10'(5 * 32);
        vga_blank_z = 1'b0;
        tick();
        check("blank_tile", 32'(tile_code), 0);
        x_pos = 10'd700;

        // Range: last valid cell is written, first invalid one is rejected
        wr_req = 1'b1; wr_addr = 9'd300; wr_data = 3'd7;
        push_err();
        wait_ack("range_err");
        tick();
        wr_req = 1'b1; wr_addr = 9'd299; wr_data = 3'd3;
        push_wr(299, 3);
        wait_ack("range_last");
        tick();

        // Frame boundary: no fetch into vertical blanking, wrap to row 0
        trigger(479);
        repeat (25) tick();
        check("no_fetch_in_vblank", 32'(fetch_busy), 0);
        push_fetch(0, 20);
        trigger(524);
        repeat (25) tick();
        y_pos = 10'd0;
        check_tile("row0_col0", 0, 3);
        check_tile("row0_col1", 1, 4);
        vga_blank_z = 1'b0;
        x_pos = 10'd700;

        // Mid-fetch reset at column 7
        push_fetch(20, 8);
        trigger(31);
        repeat (7) tick();
        @(negedge sys_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) check_tile("linebuf_cleared", c, 0);
        vga_blank_z = 1'b0;
        x_pos = 10'd700;
        repeat (30) tick();
        check("post_reset_busy", 32'(fetch_busy), 0);
        check("post_reset_addr", 32'(ram_addr), 0);
        push_fetch(20, 20);
        trigger(31);
        repeat (25) tick();
        y_pos = 10'd32;
        check_tile("refetch_col2", 2, 2);
        vga_blank_z = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
